// File: rtl/rv_datapath_pkg.sv
// rtl/rv_datapath_pkg.sv - shared constants for the RV32I datapath slice
package rv_datapath_pkg;

  localparam int XLEN = 32;

  // Instruction format codes presented by the core FSM
  localparam logic [3:0] FMT_R  = 4'd0;
  localparam logic [3:0] FMT_I  = 4'd1;
  localparam logic [3:0] FMT_IL = 4'd2;
  localparam logic [3:0] FMT_IE = 4'd3;
  localparam logic [3:0] FMT_S  = 4'd4;
  localparam logic [3:0] FMT_B  = 4'd5;
  localparam logic [3:0] FMT_J  = 4'd6;
  localparam logic [3:0] FMT_JI = 4'd7;
  localparam logic [3:0] FMT_U  = 4'd8;
  localparam logic [3:0] FMT_UP = 4'd9;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSA = 4'd10;

endpackage

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - 2R1W integer register bank with hardwired x0
module regfile_bank #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   w,
  input  logic [XLEN-1:0] data_in,
  input  logic            we,
  output logic [XLEN-1:0] data_out1,
  output logic [XLEN-1:0] data_out2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (w != '0)) begin
      regs[w] <= data_in;
    end
  end

  // No bypass: a read of the index being written returns the pre-edge value
  assign data_out1 = (rs1 == '0) ? '0 : regs[rs1];
  assign data_out2 = (rs2 == '0) ? '0 : regs[rs2];

endmodule

// File: rtl/regfile_alu_datapath.sv
// rtl/regfile_alu_datapath.sv - register file, ALU-control decoder and registered ALU
module regfile_alu_datapath #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  input  logic [$clog2(NREG)-1:0] w,
  input  logic [XLEN-1:0]         data_in,
  input  logic                    we,
  output logic [XLEN-1:0]         data_out1,
  output logic [XLEN-1:0]         data_out2,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [3:0]              fmt,
  input  logic [XLEN-1:0]         ALU_srcA,
  input  logic [XLEN-1:0]         ALU_srcB,
  output logic [3:0]              ALU_ctr,
  output logic [XLEN-1:0]         ALU_resp,
  output logic                    zero
);

  import rv_datapath_pkg::*;

  regfile_bank #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .rs1       (rs1),
    .rs2       (rs2),
    .w         (w),
    .data_in   (data_in),
    .we        (we),
    .data_out1 (data_out1),
    .data_out2 (data_out2)
  );

  // Only funct7[5] distinguishes SUB/SRA in RV32I
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    ALU_ctr = OP_ADD;
    if (fmt == FMT_R || fmt == FMT_I) begin
      case (funct3)
        3'd0:    ALU_ctr = (fmt == FMT_R && funct7[5]) ? OP_SUB : OP_ADD;
        3'd1:    ALU_ctr = OP_SLL;
        3'd2:    ALU_ctr = OP_SLT;
        3'd3:    ALU_ctr = OP_SLTU;
        3'd4:    ALU_ctr = OP_XOR;
        3'd5:    ALU_ctr = funct7[5] ? OP_SRA : OP_SRL;
        3'd6:    ALU_ctr = OP_OR;
        default: ALU_ctr = OP_AND;
      endcase
    end else if (fmt == FMT_U) begin
      ALU_ctr = OP_PASSA;
    end
  end

  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_result;

  assign shamt = ALU_srcB[4:0];

  always_comb begin
    alu_result = '0;
    case (ALU_ctr)
      OP_ADD:   alu_result = ALU_srcA + ALU_srcB;
      OP_SUB:   alu_result = ALU_srcA - ALU_srcB;
      OP_SLL:   alu_result = ALU_srcA << shamt;
      OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(ALU_srcA) < $signed(ALU_srcB)};
      OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, ALU_srcA < ALU_srcB};
      OP_XOR:   alu_result = ALU_srcA ^ ALU_srcB;
      OP_SRL:   alu_result = ALU_srcA >> shamt;
      OP_SRA:   alu_result = $unsigned($signed(ALU_srcA) >>> shamt);
      OP_OR:    alu_result = ALU_srcA | ALU_srcB;
      OP_AND:   alu_result = ALU_srcA & ALU_srcB;
      OP_PASSA: alu_result = ALU_srcA;
      default:  alu_result = '0;
    endcase
  end

  // Unconditional capture: the core depends on exactly one cycle of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      ALU_resp <= '0;
      zero     <= 1'b1;
    end else begin
      ALU_resp <= alu_result;
      zero     <= (alu_result == '0);
    end
  end

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// tb/tb_regfile_alu_datapath.sv - self-checking bench for regfile_alu_datapath
module tb_regfile_alu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, w;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_out1, data_out2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [3:0]  fmt;
  logic [31:0] ALU_srcA, ALU_srcB;
  logic [3:0]  ALU_ctr;
  logic [31:0] ALU_resp;
  logic        zero;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_regs [32];

  regfile_alu_datapath dut (
    .clk       (clk),
    .reset     (reset),
    .rs1       (rs1),
    .rs2       (rs2),
    .w         (w),
    .data_in   (data_in),
    .we        (we),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .funct3    (funct3),
    .funct7    (funct7),
    .fmt       (fmt),
    .ALU_srcA  (ALU_srcA),
    .ALU_srcB  (ALU_srcB),
    .ALU_ctr   (ALU_ctr),
    .ALU_resp  (ALU_resp),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decoder: op name chosen from the instruction semantics
  function automatic logic [3:0] ref_op(input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7);
    int alt;
    alt = f7[5];
    if (f == 4'd8) return 4'd10;
    if (f > 4'd1) return 4'd0;
    if (f3 == 3'd0) return (f == 4'd0 && alt == 1) ? 4'd1 : 4'd0;
    if (f3 == 3'd5) return (alt == 1) ? 4'd7 : 4'd6;
    if (f3 == 3'd1) return 4'd2;
    if (f3 == 3'd2) return 4'd3;
    if (f3 == 3'd3) return 4'd4;
    if (f3 == 3'd4) return 4'd5;
    if (f3 == 3'd6) return 4'd8;
    return 4'd9;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub;
    int sa, sb, sh;
    ua = longint'(a);
    ub = longint'(b);
    sa = int'(a);
    sb = int'(b);
    sh = int'(b % 32);
    case (op)
      4'd0:  return 32'((ua + ub) % 64'h1_0000_0000);
      4'd1:  return 32'((ua - ub + 64'h1_0000_0000) % 64'h1_0000_0000);
      4'd2:  return 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return 32'(ua / (64'd1 << sh));
      4'd7:  return a[31] ? ~32'((~ua & 64'hFFFF_FFFF) / (64'd1 << sh)) : 32'(ua / (64'd1 << sh));
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return a;
      default: return 32'd0;
    endcase
  endfunction

  task automatic alu_case(input string tag, input logic [3:0] f, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] exp_op, input logic [31:0] exp_res);
    fmt = f; funct3 = f3; funct7 = f7; ALU_srcA = a; ALU_srcB = b;
    #1;
    check({tag, "_ctr"}, {28'd0, ALU_ctr}, {28'd0, exp_op});
    step();
    check({tag, "_resp"}, ALU_resp, exp_res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
  endtask

  initial begin
    logic [3:0]  eop;
    logic [31:0] eres;
    reset = 1'b1; rs1 = '0; rs2 = '0; w = '0; data_in = '0; we = 1'b0;
    funct3 = '0; funct7 = '0; fmt = 4'd1; ALU_srcA = 32'h55; ALU_srcB = 32'h1;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    step();
    step();
    check("reset_zero", {31'd0, zero}, 32'd1);
    check("reset_resp", ALU_resp, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      check($sformatf("reset_x%0d", i), data_out1, 32'd0);
      check($sformatf("reset_x%0d_b", 31 - i), data_out2, 32'd0);
    end

    w = 5'd5; data_in = 32'hDEADBEEF; we = 1'b1; rs1 = 5'd5;
    #1;
    check("wr_same_cycle", data_out1, 32'd0);
    step();
    we = 1'b0;
    #1;
    check("wr_after_edge", data_out1, 32'hDEADBEEF);
    model_regs[5] = 32'hDEADBEEF;
    w = 5'd0; data_in = 32'h1234; we = 1'b1; rs1 = 5'd0;
    step();
    we = 1'b0;
    #1;
    check("x0_discard", data_out1, 32'd0);

    alu_case("sub",  4'd0, 3'd0, 7'h20, 32'd5, 32'd7, 4'd1, 32'hFFFFFFFE);
    alu_case("sra",  4'd1, 3'd5, 7'h20, 32'h80000000, 32'd4, 4'd7, 32'hF8000000);
    alu_case("srl",  4'd0, 3'd5, 7'h00, 32'h80000000, 32'd4, 4'd6, 32'h08000000);
    alu_case("slt",  4'd0, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 4'd3, 32'd1);
    alu_case("sltu", 4'd0, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 4'd4, 32'd0);
    alu_case("addi_f7", 4'd1, 3'd0, 7'h20, 32'd9, 32'd3, 4'd0, 32'd12);
    alu_case("add_zero", 4'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'd1, 4'd0, 32'd0);
    alu_case("fmt15", 4'd15, 3'd4, 7'h20, 32'd2, 32'd3, 4'd0, 32'd5);

    fmt = 4'd6; ALU_srcA = 32'h100; ALU_srcB = 32'h4;
    step();
    check("b2b_1", ALU_resp, 32'h104);
    ALU_srcB = 32'h20;
    step();
    check("b2b_2", ALU_resp, 32'h120);

    alu_case("lui", 4'd8, 3'd0, 7'h00, 32'h12345000, 32'h0, 4'd10, 32'h12345000);
    fmt = 4'd9; ALU_srcA = ALU_resp; ALU_srcB = 32'h40;
    step();
    check("auipc_chain", ALU_resp, 32'h12345040);

    fmt = 4'd0; funct3 = 3'd6; ALU_srcA = 32'hF0; ALU_srcB = 32'h0F;
    w = 5'd3; data_in = 32'hAAAA5555; we = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; we = 1'b0; rs1 = 5'd3; rs2 = 5'd5;
    check("rst_mid_resp", ALU_resp, 32'd0);
    check("rst_mid_zero", {31'd0, zero}, 32'd1);
    #1;
    check("rst_mid_wr", data_out1, 32'd0);
    check("rst_clears_x5", data_out2, 32'd0);
    model_regs[5] = 32'd0;

    for (int n = 0; n < 300; n++) begin
      fmt = 4'($urandom_range(0, 15));
      if (n % 3 != 0) fmt = 4'($urandom_range(0, 1));
      funct3 = 3'($urandom);
      funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
      ALU_srcA = $urandom;
      ALU_srcB = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) ALU_srcB = ALU_srcA;
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      w = 5'($urandom); data_in = $urandom; we = 1'($urandom);
      #1;
      eop = ref_op(fmt, funct3, funct7);
      eres = ref_alu(eop, ALU_srcA, ALU_srcB);
      check($sformatf("rnd%0d_ctr", n), {28'd0, ALU_ctr}, {28'd0, eop});
      check($sformatf("rnd%0d_rd1", n), data_out1, model_regs[rs1]);
      check($sformatf("rnd%0d_rd2", n), data_out2, model_regs[rs2]);
      step();
      if (we && w != 5'd0) model_regs[w] = data_in;
      check($sformatf("rnd%0d_resp", n), ALU_resp, eres);
      check($sformatf("rnd%0d_zero", n), {31'd0, zero}, {31'd0, eres == 32'd0});
    end
    we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_alu_datapath.md
# regfile_alu_datapath

RV32I integer datapath slice for the multicycle core: a 32×32 register file, the ALU-control decoder and a registered ALU. The core FSM drives register indices, instruction fields, format code and ALU operands. It reads back register operands combinationally and the ALU result one clock later. Branch comparison, memory alignment and PC update stay in the core.

## Interface
Parameters:
- XLEN, 32, datapath width (only 32 supported)
- NREG, 32, register count; index width log2(NREG)=5

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- reset  in  1  synchronous, active-high reset
- rs1  in  5  read index A
- rs2  in  5  read index B
- w  in  5  write index (rd)
- data_in  in  32  write data
- we  in  1  register write enable
- data_out1  out  32  x[rs1], combinational
- data_out2  out  32  x[rs2], combinational
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- fmt  in  4  format code: R=0, I=1, IL=2, IE=3, S=4, B=5, J=6, JI=7, U=8, UP=9
- ALU_srcA  in  32  operand A
- ALU_srcB  in  32  operand B
- ALU_ctr  out  4  decoded op, combinational
- ALU_resp  out  32  registered result
- zero  out  1  registered, 1 when ALU_resp==0

## Operation
- Decoder, combinational. Op codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSA=10.
- fmt R, funct3 → op: 0 → ADD, or SUB if funct7[5]; 1 SLL; 2 SLT; 3 SLTU; 4 XOR; 5 SRL, or SRA if funct7[5]; 6 OR; 7 AND.
- fmt I: same mapping as R, except funct3=0 is always ADD (funct7 ignored).
- fmt U → PASSA.
- fmt IL, IE, S, B, J, JI, UP and codes 10–15 → ADD.
- ALU: result computed from ALU_srcA, ALU_srcB and the current ALU_ctr.
  - Shift amount is B[4:0].
  - SLT is signed; SLTU is unsigned; result is 0/1 zero-extended.
  - Arithmetic wraps modulo 2^32; no flags other than zero.
  - Codes 11–15 → result 0.
- Register file:
  - x0 reads 0 always; writes to w=0 are discarded.
  - Reads are combinational and have no write bypass.

## Timing
- Reset, on any edge with reset=1: all 32 registers ← 0, ALU_resp ← 0, zero ← 1. Reset overrides we.
- Register write: on a posedge with we=1 and reset=0, x[w] ← data_in. During that cycle a same-index read returns the old value; the new value is visible after the edge.
- ALU latency is exactly 1 clock. The operands and fmt/funct present before edge N determine ALU_resp and zero after edge N. ALU_resp updates on every non-reset edge; there is no enable.
- The core relies on this latency for:
  - reading pc+4 while presenting a jump target;
  - chaining a result back as ALU_srcA (AUIPC: PASSA then ADD with pc).
- Decoder outputs and read ports have zero latency.
- Reset mid-operation discards any in-flight ALU result. A write asserted in the same cycle as reset does not happen.

## Structure
- Shared package `rv_datapath_pkg`: fmt code constants, ALU op constants, XLEN.
- One sub-module: `regfile_bank`, holding the register array, the 2R1W ports and the x0 rule.
- Decoder and ALU stay inline in the top module.

## Test plan
- Reset, then read all 32 indices → all 0; zero=1, ALU_resp=0.
- Write x5=0xDEADBEEF. Same-cycle read of rs1=5 → 0; next cycle → 0xDEADBEEF. Write x0=0x1234 → x0 reads 0.
- fmt=R, funct3=0, funct7=0x20, A=5, B=7 → ALU_ctr=SUB. After one edge ALU_resp=0xFFFFFFFE, zero=0.
- fmt=I, funct3=5, funct7=0x20, A=0x80000000, B=4 → SRA → 0xF8000000.
- fmt=R, funct3=5, funct7=0, same A and B → SRL → 0x08000000.
- fmt=R, funct3=2, A=0xFFFFFFFF, B=1 → SLT → 1. fmt=R, funct3=3, same A and B → SLTU → 0.
- Back-to-back ops, one per cycle:
  - Cycle 1: fmt=J, A=0x100, B=4.
  - Cycle 2: fmt=J, A=0x100, B=0x20.
  - Results: 0x104 after edge 1, 0x120 after edge 2.
- fmt=U, A=0x12345000 → after one edge 0x12345000.
- Chain: next cycle A=ALU_resp, B=0x40, fmt=UP → 0x12345040.
